regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the NPC core.
- Provides NR_RD combinational read ports, NR_WR prioritised write ports, optional write-to-read bypass, and a per-register busy scoreboard (pending-write tracking).
- Sits between decode/issue (reads, allocation) and writeback (writes); decode stalls on a read port whose rvalid is low.

Parameters:
- DATA_WIDTH, 32, register width in bits
- REG_NUM, 32, number of architectural registers (power of two)
- ADDR_WIDTH, 5, log2(REG_NUM)
- NR_RD, 2, number of read ports
- NR_WR, 2, number of write ports
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see only stored state
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and never busy

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- wen  in  NR_WR  per-port write enable
- waddr  in  NR_WR*ADDR_WIDTH  write addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- wdata  in  NR_WR*DATA_WIDTH  write data, packed the same way
- alloc_en  in  1  mark a destination register as pending (issue)
- alloc_addr  in  ADDR_WIDTH  destination being allocated
- raddr  in  NR_RD*ADDR_WIDTH  read addresses
- rdata  out  NR_RD*DATA_WIDTH  read data
- rvalid  out  NR_RD  1 = rdata holds the final value (no outstanding writer)
- busy_vec  out  REG_NUM  current scoreboard bits, for debug/difftest

Behaviour:
- Reset: rst_n low asynchronously clears every register to 0 and every busy bit to 0. While reset is asserted and after release, reads return 0 with rvalid=1. Reset mid-operation discards pending allocations.
- Write: on posedge, for each port i with wen[i], rf[waddr[i]] <= wdata[i] and busy[waddr[i]] is cleared. Latency is 1 cycle to storage.
- Write collision: two enabled ports with the same address resolve to the highest-index port for data. Busy is cleared once.
- Zero register (ZERO_REG=1): writes to address 0 are ignored, alloc to 0 is ignored, and reads of 0 return 0 with rvalid=1 regardless of BYPASS.
- Allocation: on posedge, alloc_en sets busy[alloc_addr].
- Alloc and write to the same address in the same cycle: alloc wins, so busy ends at 1. The write still updates the data, because it belongs to the older producer.
- Read (combinational, 0 latency):
  - BYPASS=1: if any wen[i] matches raddr[p] this cycle, rdata is that port's wdata (highest index wins) and rvalid=1. Otherwise rdata=rf[raddr], rvalid=~busy[raddr].
  - BYPASS=0: rdata=rf[raddr], rvalid=~busy[raddr]. A write in the current cycle becomes visible the next cycle.
- Same-cycle alloc does not affect rvalid until the next cycle, because busy is a registered bit.
- Widths: no arithmetic. Address compares are full ADDR_WIDTH. Out-of-range addresses cannot occur because REG_NUM = 2^ADDR_WIDTH.
- No handshake back-pressure: writes are always accepted.

Decomposition:
- Shared package/header holds DATA_WIDTH, ADDR_WIDTH, REG_NUM defaults and the port-packing helpers.
- One sub-module, regfile_scoreboard, holds the busy vector and the alloc/clear priority logic. The storage array and read muxes stay in regfile_mp.

Test Plan:
- Assert rst_n=0 mid-run after writing x5=0xDEADBEEF -> rdata(x5)=0 and all rvalid=1 immediately, before any clock edge. busy_vec=0.
- wen[0] x3=0x11 -> next cycle raddr0=3 gives 0x11. With BYPASS=1, the same-cycle read also returns 0x11; with BYPASS=0 it returns the old value 0.
- wen[0] and wen[1] both to x7 (0xAAAA, 0x5555) -> next cycle x7=0x5555. Bypass read in the same cycle also gives 0x5555.
- Write to x0=0xFFFFFFFF and alloc x0 -> rdata(x0)=0, rvalid=1, busy_vec[0]=0.
- Alloc x9 at cycle t -> rvalid(x9)=0 from t+1. wen x9=0x42 at t+3 -> BYPASS=1: rvalid=1 with 0x42 in t+3. BYPASS=0: rvalid=1 from t+4.
- Same-cycle alloc x4 and write x4=0x99 -> next cycle rdata(x4)=0x99 with rvalid=0, busy_vec[4]=1.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared defaults and port-packing helpers for the multi-port register file.
package regfile_mp_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_REG_NUM    = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  // Low bit of lane idx inside a packed bus of width-bit lanes.
  function automatic int slot_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Busy scoreboard: one pending-write bit per register, alloc beats same-cycle clear.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int REG_NUM    = DEF_REG_NUM,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_NUM-1:0]    i_clr,
  input  logic                  i_alloc_en,
  input  logic [ADDR_WIDTH-1:0] i_alloc_addr,
  output logic [REG_NUM-1:0]    o_busy
);

  logic [REG_NUM-1:0] r_busy;
  logic [REG_NUM-1:0] w_set;

  always_comb begin
    w_set = '0;
    for (int r = 0; r < REG_NUM; r++) begin
      if (i_alloc_en && (i_alloc_addr == ADDR_WIDTH'(r)) && !(ZERO_REG != 0 && r == 0))
        w_set[r] = 1'b1;
    end
  end

  // The set term is OR'd after the clear so a new allocation outlives an older writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= (r_busy & ~i_clr) | w_set;
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with prioritised writes, optional bypass and busy tracking.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_NUM    = DEF_REG_NUM,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NR_RD      = 2,
  parameter int NR_WR      = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NR_WR-1:0]            wen,
  input  logic [NR_WR*ADDR_WIDTH-1:0] waddr,
  input  logic [NR_WR*DATA_WIDTH-1:0] wdata,
  input  logic                        alloc_en,
  input  logic [ADDR_WIDTH-1:0]       alloc_addr,
  input  logic [NR_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NR_RD*DATA_WIDTH-1:0] rdata,
  output logic [NR_RD-1:0]            rvalid,
  output logic [REG_NUM-1:0]          busy_vec
);

  logic [DATA_WIDTH-1:0] r_rf [REG_NUM];
  logic [NR_WR-1:0]      w_wen_eff;
  logic [REG_NUM-1:0]    w_clr;
  logic [REG_NUM-1:0]    w_busy;

  // Writes to x0 are dropped up front so storage, clear and bypass all agree.
  always_comb begin
    w_wen_eff = '0;
    for (int i = 0; i < NR_WR; i++) begin
      w_wen_eff[i] = wen[i] &&
        !(ZERO_REG != 0 && waddr[slot_lo(i, ADDR_WIDTH) +: ADDR_WIDTH] == '0);
    end
  end

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NR_WR; i++) begin
      if (w_wen_eff[i]) w_clr[waddr[slot_lo(i, ADDR_WIDTH) +: ADDR_WIDTH]] = 1'b1;
    end
  end

  // Ascending loop order makes the highest-index port win a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REG_NUM; r++) r_rf[r] <= '0;
    end else begin
      for (int i = 0; i < NR_WR; i++) begin
        if (w_wen_eff[i])
          r_rf[waddr[slot_lo(i, ADDR_WIDTH) +: ADDR_WIDTH]] <= wdata[slot_lo(i, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  regfile_scoreboard #(
    .REG_NUM    (REG_NUM),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr        (w_clr),
    .i_alloc_en   (alloc_en),
    .i_alloc_addr (alloc_addr),
    .o_busy       (w_busy)
  );

  assign busy_vec = w_busy;

  for (genvar p = 0; p < NR_RD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_ra;
    logic [DATA_WIDTH-1:0] w_rd;
    logic                  w_rv;

    assign w_ra = raddr[p*ADDR_WIDTH +: ADDR_WIDTH];

    // Bypass is held off during reset so reads report the cleared state.
    always_comb begin
      w_rd = r_rf[w_ra];
      w_rv = ~w_busy[w_ra];
      if (BYPASS != 0 && rst_n) begin
        for (int i = 0; i < NR_WR; i++) begin
          if (w_wen_eff[i] && waddr[slot_lo(i, ADDR_WIDTH) +: ADDR_WIDTH] == w_ra) begin
            w_rd = wdata[slot_lo(i, DATA_WIDTH) +: DATA_WIDTH];
            w_rv = 1'b1;
          end
        end
      end
      if (ZERO_REG != 0 && w_ra == '0) begin
        w_rd = '0;
        w_rv = 1'b1;
      end
    end

    assign rdata[p*DATA_WIDTH +: DATA_WIDTH] = w_rd;
    assign rvalid[p]                         = w_rv;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance on shared inputs.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wen;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic [9:0]  raddr;
  logic [63:0] rdata_b, rdata_n;
  logic [1:0]  rvalid_b, rvalid_n;
  logic [31:0] busy_b, busy_n;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .raddr(raddr),
    .rdata(rdata_b), .rvalid(rvalid_b), .busy_vec(busy_b)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .raddr(raddr),
    .rdata(rdata_n), .rvalid(rvalid_n), .busy_vec(busy_n)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = '0; waddr = '0; wdata = '0; alloc_en = 1'b0; alloc_addr = '0;
  endtask

  initial begin
    rst_n = 1'b0; idle(); raddr = '0;
    #1;
    chk("reset_rdata", {rdata_b, rdata_n}, 128'h0);
    chk("reset_rvalid", {rvalid_b, rvalid_n}, 4'b1111);
    chk("reset_busy", {busy_b, busy_n}, 64'h0);
    step(); step();
    rst_n = 1'b1;
    step();

    // write x5 and allocate x6, then reset mid-run
    wen = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEADBEEF};
    alloc_en = 1'b1; alloc_addr = 5'd6;
    step(); idle();
    raddr = {5'd6, 5'd5};
    #1;
    chk("x5_written", {32'h0, rdata_n[31:0]}, 64'hDEADBEEF);
    chk("x6_busy", {62'h0, rvalid_n}, 64'b01);
    rst_n = 1'b0;
    #1;
    chk("midrst_rdata", {rdata_b, rdata_n}, 128'h0);
    chk("midrst_rvalid", {rvalid_b, rvalid_n}, 4'b1111);
    chk("midrst_busy", {busy_b, busy_n}, 64'h0);
    step();
    rst_n = 1'b1;
    step();

    // single write x3: bypass vs stored view
    wen = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h11}; raddr = {5'd0, 5'd3};
    #1;
    chk("x3_bypass_same", {32'h0, rdata_b[31:0]}, 64'h11);
    chk("x3_nobypass_same", {32'h0, rdata_n[31:0]}, 64'h0);
    step(); idle();
    #1;
    chk("x3_next", {rdata_b[31:0], rdata_n[31:0]}, {32'h11, 32'h11});

    // collision on x7: port 1 wins
    wen = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h5555, 32'hAAAA}; raddr = {5'd7, 5'd0};
    #1;
    chk("x7_bypass_same", {32'h0, rdata_b[63:32]}, 64'h5555);
    step(); idle();
    #1;
    chk("x7_next", {rdata_b[63:32], rdata_n[63:32]}, {32'h5555, 32'h5555});

    // zero register write and alloc are ignored
    wen = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'hFFFFFFFF};
    alloc_en = 1'b1; alloc_addr = 5'd0; raddr = {5'd0, 5'd0};
    #1;
    chk("x0_same", {rdata_b[31:0], 31'h0, rvalid_b[0]}, 64'h1);
    step(); idle();
    #1;
    chk("x0_rdata", {rdata_b[31:0], rdata_n[31:0]}, 64'h0);
    chk("x0_rvalid", {62'h0, rvalid_b[0], rvalid_n[0]}, 64'b11);
    chk("x0_busy", {62'h0, busy_b[0], busy_n[0]}, 64'b00);

    // alloc x9 at t, write at t+3
    alloc_en = 1'b1; alloc_addr = 5'd9; raddr = {5'd0, 5'd9};
    #1;
    chk("x9_t_valid", {62'h0, rvalid_b[0], rvalid_n[0]}, 64'b11);
    step(); idle();
    #1;
    chk("x9_t1_valid", {62'h0, rvalid_b[0], rvalid_n[0]}, 64'b00);
    chk("x9_t1_busy", {62'h0, busy_b[9], busy_n[9]}, 64'b11);
    step();
    chk("x9_t2_valid", {62'h0, rvalid_b[0], rvalid_n[0]}, 64'b00);
    step();
    wen = 2'b10; waddr = {5'd9, 5'd0}; wdata = {32'h42, 32'h0};
    #1;
    chk("x9_t3_bypass", {rdata_b[31:0], 31'h0, rvalid_b[0]}, {32'h42, 32'h1});
    chk("x9_t3_nobypass", {62'h0, rvalid_n[0]}, 64'h0);
    step(); idle();
    #1;
    chk("x9_t4_nobypass", {rdata_n[31:0], 31'h0, rvalid_n[0]}, {32'h42, 32'h1});
    chk("x9_t4_busy", {62'h0, busy_b[9], busy_n[9]}, 64'b00);

    // same-cycle alloc and write on x4: data lands, busy stays
    alloc_en = 1'b1; alloc_addr = 5'd4;
    wen = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'h99}; raddr = {5'd4, 5'd0};
    step(); idle();
    #1;
    chk("x4_rdata", {rdata_b[63:32], rdata_n[63:32]}, {32'h99, 32'h99});
    chk("x4_rvalid", {62'h0, rvalid_b[1], rvalid_n[1]}, 64'b00);
    chk("x4_busy", {62'h0, busy_b[4], busy_n[4]}, 64'b11);

    // earlier results survive later traffic
    raddr = {5'd7, 5'd3};
    #1;
    chk("x3_x7_hold", {rdata_n[63:32], rdata_n[31:0]}, {32'h5555, 32'h11});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
